// File: rtl/nand_bus_sequencer_pkg.sv
// Shared opcode values, FSM state encoding and default ONFI async timing for
// the NAND bus sequencer.
package nand_bus_sequencer_pkg;

  typedef logic [2:0] op_type_t;

  localparam op_type_t OP_CMD     = 3'd0;
  localparam op_type_t OP_ADDR    = 3'd1;
  localparam op_type_t OP_DATA_WR = 3'd2;
  localparam op_type_t OP_DATA_RD = 3'd3;
  localparam op_type_t OP_WAIT_RB = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STROBE_LO = 3'd2,
    ST_STROBE_HI = 3'd3,
    ST_TWB       = 3'd4,
    ST_RB_WAIT   = 3'd5
  } state_e;

  localparam int TWP_CYC_DEF   = 2;
  localparam int TWH_CYC_DEF   = 2;
  localparam int TWB_CYC_DEF   = 4;
  localparam int TIMEOUT_W_DEF = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nand_bus_sequencer_if.sv
// Request/response channel between the APB front end (master) and the NAND
// bus sequencer (slave).
interface nand_bus_sequencer_if;
  import nand_bus_sequencer_pkg::*;

  logic     op_valid;
  logic     op_ready;
  op_type_t op_type;
  logic [7:0] op_data;
  logic     op_last;
  logic     rd_valid;
  logic [7:0] rd_data;
  logic     op_err;

  modport master (
    output op_valid, op_type, op_data, op_last,
    input  op_ready, rd_valid, rd_data, op_err
  );

  modport slave (
    input  op_valid, op_type, op_data, op_last,
    output op_ready, rd_valid, rd_data, op_err
  );

endinterface

// File: rtl/nand_rb_sync.sv
// Two-flop synchronizer for the asynchronous NAND ready/busy pin; resets to
// "ready" so a busy indication is never fabricated out of reset.
module nand_rb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rb_n_async,
  output logic rb_n_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the pad value through the two stages
  always_comb begin
    sync_d = {sync_q[0], rb_n_async};
  end

  // synchronizer flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rb_n_sync = sync_q[1];

endmodule

// File: rtl/nand_bus_sequencer.sv
// Executes one NAND bus operation per accepted request with cycle-counted
// strobe timing; every NAND pin comes straight from a flop.
module nand_bus_sequencer
  import nand_bus_sequencer_pkg::*;
#(
  parameter int TWP_CYC   = TWP_CYC_DEF,
  parameter int TWH_CYC   = TWH_CYC_DEF,
  parameter int TWB_CYC   = TWB_CYC_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  nand_bus_sequencer_if.slave  op_if,
  input  logic                 wp_release,
  output logic                 nCE,
  output logic                 CLE,
  output logic                 ALE,
  output logic                 nWE,
  output logic                 nRE,
  output logic                 nWP,
  output logic [7:0]           IO_out,
  output logic                 IO_oe,
  input  logic [7:0]           IO_in,
  input  logic                 RB_n
);

  localparam int PHASE_MAX = max3(TWP_CYC, TWH_CYC, TWB_CYC);
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [PW-1:0]        CNT_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]        CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]        TWP_LOAD = PW'(TWP_CYC - 1);
  localparam logic [PW-1:0]        TWH_LOAD = PW'(TWH_CYC - 1);
  localparam logic [PW-1:0]        TWB_LOAD = PW'(TWB_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] RB_ZERO  = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] RB_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] RB_LIMIT = {TIMEOUT_W{1'b1}};

  state_e                state_q, state_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]  rb_cnt_q, rb_cnt_d;
  logic                  is_rd_q, is_rd_d;
  logic                  last_q, last_d;
  logic                  op_ready_q, op_ready_d;
  logic                  op_err_q, op_err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  nce_q, nce_d;
  logic                  cle_q, cle_d;
  logic                  ale_q, ale_d;
  logic                  nwe_q, nwe_d;
  logic                  nre_q, nre_d;
  logic                  nwp_q, nwp_d;
  logic [7:0]            io_out_q, io_out_d;
  logic                  io_oe_q, io_oe_d;

  logic                  rb_ready_s;
  logic                  accept_s;
  logic [TIMEOUT_W-1:0]  rb_cnt_inc_s;

  nand_rb_sync u_rb_sync (
    .clk        (PCLK),
    .rst_n      (PRESETN),
    .rb_n_async (RB_n),
    .rb_n_sync  (rb_ready_s)
  );

  assign accept_s     = op_if.op_valid && op_ready_q;
  assign rb_cnt_inc_s = rb_cnt_q + RB_ONE;

  // next-state and next-pin computation; the phase counter counts down to zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rb_cnt_d  = rb_cnt_q;
    is_rd_d   = is_rd_q;
    last_d    = last_q;
    nce_d     = nce_q;
    cle_d     = cle_q;
    ale_d     = ale_q;
    io_out_d  = io_out_q;
    io_oe_d   = io_oe_q;
    rd_data_d = rd_data_q;
    op_err_d  = 1'b0;
    nwp_d     = wp_release;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_if.op_type)
            OP_CMD, OP_ADDR, OP_DATA_WR, OP_DATA_RD: begin
              state_d  = ST_SETUP;
              nce_d    = 1'b0;
              last_d   = op_if.op_last;
              is_rd_d  = (op_if.op_type == OP_DATA_RD);
              cle_d    = (op_if.op_type == OP_CMD);
              ale_d    = (op_if.op_type == OP_ADDR);
              io_oe_d  = (op_if.op_type != OP_DATA_RD);
              io_out_d = (op_if.op_type != OP_DATA_RD) ? op_if.op_data : 8'h00;
            end
            OP_WAIT_RB: begin
              state_d = ST_TWB;
              cnt_d   = TWB_LOAD;
              nce_d   = 1'b0;
              last_d  = op_if.op_last;
              is_rd_d = 1'b0;
              io_oe_d = 1'b0;
            end
            default: begin
              op_err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE_LO;
        cnt_d   = TWP_LOAD;
      end
      ST_STROBE_LO: begin
        if (cnt_q == CNT_ZERO) begin
          state_d   = ST_STROBE_HI;
          cnt_d     = TWH_LOAD;
          rd_data_d = is_rd_q ? IO_in : rd_data_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE_HI: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = ST_IDLE;
          nce_d    = last_q;
          cle_d    = 1'b0;
          ale_d    = 1'b0;
          io_oe_d  = 1'b0;
          io_out_d = 8'h00;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_TWB: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = ST_RB_WAIT;
          rb_cnt_d = RB_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RB_WAIT: begin
        rb_cnt_d = rb_cnt_inc_s;
        // exit on ready, or flag a timeout once the counter would hit all-ones
        if (rb_ready_s || (rb_cnt_inc_s == RB_LIMIT)) begin
          state_d  = ST_IDLE;
          nce_d    = last_q;
          op_err_d = !rb_ready_s;
        end else begin
          state_d = ST_RB_WAIT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        nce_d    = 1'b1;
        cle_d    = 1'b0;
        ale_d    = 1'b0;
        io_oe_d  = 1'b0;
        io_out_d = 8'h00;
      end
    endcase
    nwe_d      = !((state_d == ST_STROBE_LO) && !is_rd_d);
    nre_d      = !((state_d == ST_STROBE_LO) && is_rd_d);
    rd_valid_d = is_rd_d && (state_d == ST_STROBE_HI) && (cnt_d == CNT_ZERO);
    op_ready_d = (state_d == ST_IDLE);
  end

  // FSM, counters and registered outputs with synchronous reset
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      rb_cnt_q   <= RB_ZERO;
      is_rd_q    <= 1'b0;
      last_q     <= 1'b0;
      op_ready_q <= 1'b0;
      op_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      nce_q      <= 1'b1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      nwe_q      <= 1'b1;
      nre_q      <= 1'b1;
      nwp_q      <= 1'b0;
      io_out_q   <= 8'h00;
      io_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rb_cnt_q   <= rb_cnt_d;
      is_rd_q    <= is_rd_d;
      last_q     <= last_d;
      op_ready_q <= op_ready_d;
      op_err_q   <= op_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      nce_q      <= nce_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      nwe_q      <= nwe_d;
      nre_q      <= nre_d;
      nwp_q      <= nwp_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
    end
  end

  assign op_if.op_ready = op_ready_q;
  assign op_if.op_err   = op_err_q;
  assign op_if.rd_valid = rd_valid_q;
  assign op_if.rd_data  = rd_data_q;
  assign nCE            = nce_q;
  assign CLE            = cle_q;
  assign ALE            = ale_q;
  assign nWE            = nwe_q;
  assign nRE            = nre_q;
  assign nWP            = nwp_q;
  assign IO_out         = io_out_q;
  assign IO_oe          = io_oe_q;

endmodule

// File: tb/tb_nand_bus_sequencer.sv
// Self-checking bench for nand_bus_sequencer: directed ops with a scoreboard of
// expected read bytes / errors, plus a short-timeout instance for RB timeouts.
module tb_nand_bus_sequencer;
  import nand_bus_sequencer_pkg::*;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } sb_t;

  logic       PCLK;
  logic       PRESETN;
  logic       wp_release;
  logic       RB_n;
  logic       RB_n_to;
  logic [7:0] IO_in;

  logic       nCE, CLE, ALE, nWE, nRE, nWP, IO_oe;
  logic [7:0] IO_out;
  logic       nCE_to, CLE_to, ALE_to, nWE_to, nRE_to, nWP_to, IO_oe_to;
  logic [7:0] IO_out_to;
  logic [6:0] pins_s;

  nand_bus_sequencer_if bus ();
  nand_bus_sequencer_if bus_to ();

  int  n_cmp = 0;
  int  n_err = 0;
  int  rdv_n = 0;
  sb_t sb_q[$];
  sb_t mon_e;

  nand_bus_sequencer dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .op_if(bus), .wp_release(wp_release),
    .nCE(nCE), .CLE(CLE), .ALE(ALE), .nWE(nWE), .nRE(nRE), .nWP(nWP),
    .IO_out(IO_out), .IO_oe(IO_oe), .IO_in(IO_in), .RB_n(RB_n)
  );

  nand_bus_sequencer #(.TIMEOUT_W(4)) dut_to (
    .PCLK(PCLK), .PRESETN(PRESETN), .op_if(bus_to), .wp_release(wp_release),
    .nCE(nCE_to), .CLE(CLE_to), .ALE(ALE_to), .nWE(nWE_to), .nRE(nRE_to), .nWP(nWP_to),
    .IO_out(IO_out_to), .IO_oe(IO_oe_to), .IO_in(IO_in), .RB_n(RB_n_to)
  );

  assign pins_s = {nCE, CLE, ALE, nWE, nRE, nWP, IO_oe};

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every rd_valid / op_err pulse must match the next entry
  always @(negedge PCLK) begin
    if (bus.rd_valid === 1'b1) begin
      rdv_n++;
      check_val("sb_rd_pending", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_val("sb_rd_kind", mon_e.is_err, 0);
        check_val("sb_rd_data", bus.rd_data, mon_e.data);
      end
    end
    if (bus.op_err === 1'b1) begin
      check_val("sb_err_pending", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_val("sb_err_kind", mon_e.is_err, 1);
      end
    end
  end

  // Issue one op at a negedge, then watch pins until op_ready returns (bounded)
  task automatic do_op(input logic [2:0] t, input logic [7:0] d, input logic l, input int rb_rel,
                       output int lat, output int nwe_lo, output int nre_lo,
                       output logic [6:0] pins1, output logic [7:0] io1, output int rdv_k);
    lat = -1; nwe_lo = 0; nre_lo = 0; rdv_k = -1; pins1 = 7'h00; io1 = 8'h00;
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_data  = d;
    bus.op_last  = l;
    RB_n         = (rb_rel == 0);
    if (t == OP_DATA_RD) sb_q.push_back('{is_err: 1'b0, data: d});
    if (t > OP_WAIT_RB)  sb_q.push_back('{is_err: 1'b1, data: 8'h00});
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge PCLK);
      if (k == 1) begin
        bus.op_valid = 1'b0;
        pins1 = pins_s;
        io1   = IO_out;
      end
      if (nWE === 1'b0) nwe_lo++;
      if (nRE === 1'b0) nre_lo++;
      IO_in = (nRE === 1'b0) ? d : 8'h5A;
      if (bus.rd_valid === 1'b1) rdv_k = k;
      if (k == rb_rel) RB_n = 1'b1;
      if (bus.op_ready === 1'b1) lat = k;
    end
  endtask

  int         lat, nwe_lo, nre_lo, rdv_k, rdv_before;
  int         err_k, err_n, rdy_k;
  logic [6:0] pins1;
  logic [7:0] io1;

  initial begin
    PRESETN = 1'b0; wp_release = 1'b0; RB_n = 1'b1; RB_n_to = 1'b1; IO_in = 8'h5A;
    bus.op_valid = 1'b0; bus.op_type = 3'd0; bus.op_data = 8'h00; bus.op_last = 1'b0;
    bus_to.op_valid = 1'b0; bus_to.op_type = 3'd0; bus_to.op_data = 8'h00; bus_to.op_last = 1'b0;

    repeat (3) @(negedge PCLK);
    check_val("rst_ready", bus.op_ready, 0);
    check_val("rst_pins", pins_s, 7'b1001100);
    check_val("rst_io_out", IO_out, 8'h00);
    check_val("rst_flags", {bus.rd_valid, bus.op_err}, 2'b00);
    PRESETN = 1'b1; wp_release = 1'b1;
    @(negedge PCLK);
    check_val("rel_ready", bus.op_ready, 1);
    check_val("rel_nwp", nWP, 1);

    do_op(OP_CMD, 8'h70, 1'b0, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("cmd_lat", lat, 6);
    check_val("cmd_nwe_lo", nwe_lo, 2);
    check_val("cmd_nre_lo", nre_lo, 0);
    check_val("cmd_pins", pins1, 7'b0101111);
    check_val("cmd_io", io1, 8'h70);
    check_val("cmd_end_pins", pins_s, 7'b0001110);

    do_op(OP_ADDR, 8'h12, 1'b0, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("addr1_lat", lat, 6);
    check_val("addr1_nwe_lo", nwe_lo, 2);
    check_val("addr1_pins", pins1, 7'b0011111);
    check_val("addr1_io", io1, 8'h12);
    do_op(OP_ADDR, 8'h34, 1'b0, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("addr2_lat", lat, 6);
    check_val("addr2_nwe_lo", nwe_lo, 2);
    check_val("addr2_pins", pins1, 7'b0011111);
    check_val("addr2_io", io1, 8'h34);

    rdv_before = rdv_n;
    do_op(OP_DATA_RD, 8'hA5, 1'b1, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("rd_lat", lat, 6);
    check_val("rd_nre_lo", nre_lo, 2);
    check_val("rd_nwe_lo", nwe_lo, 0);
    check_val("rd_pins", pins1, 7'b0001110);
    check_val("rd_valid_cycle", rdv_k, 5);
    check_val("rd_valid_pulses", rdv_n - rdv_before, 1);
    check_val("rd_end_pins", pins_s, 7'b1001110);
    check_val("rd_hold", bus.rd_data, 8'hA5);

    do_op(OP_WAIT_RB, 8'h00, 1'b0, 20, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("rb_lat", lat, 23);
    check_val("rb_strobes", nwe_lo + nre_lo, 0);
    check_val("rb_pins", pins1, 7'b0001110);
    check_val("rb_end_pins", pins_s, 7'b0001110);

    do_op(OP_WAIT_RB, 8'h00, 1'b1, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("rbfast_lat", lat, 6);
    check_val("rbfast_end_pins", pins_s, 7'b1001110);

    bus_to.op_valid = 1'b1; bus_to.op_type = OP_WAIT_RB; bus_to.op_last = 1'b1; RB_n_to = 1'b0;
    err_k = -1; err_n = 0; rdy_k = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge PCLK);
      if (k == 1) bus_to.op_valid = 1'b0;
      if (bus_to.op_err === 1'b1) begin
        err_n++;
        if (err_k < 0) err_k = k;
      end
      if ((bus_to.op_ready === 1'b1) && (rdy_k < 0)) rdy_k = k;
    end
    check_val("to_err_cycle", err_k, 20);
    check_val("to_err_pulses", err_n, 1);
    check_val("to_ready_cycle", rdy_k, 20);
    check_val("to_nce", nCE_to, 1);

    bus.op_valid = 1'b1; bus.op_type = OP_DATA_WR; bus.op_data = 8'h3C; bus.op_last = 1'b0;
    @(negedge PCLK);
    bus.op_valid = 1'b0;
    @(negedge PCLK);
    check_val("wr_strobe_lo", nWE, 0);
    PRESETN = 1'b0;
    @(negedge PCLK);
    check_val("abort_pins", {nCE, nWE, IO_oe}, 3'b110);
    check_val("abort_ready", bus.op_ready, 0);
    PRESETN = 1'b1;
    @(negedge PCLK);
    check_val("abort_rel_ready", bus.op_ready, 1);

    do_op(3'd6, 8'hFF, 1'b0, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("ill6_lat", lat, 1);
    check_val("ill6_err", bus.op_err, 1);
    check_val("ill6_pins", pins1, 7'b1001110);
    check_val("ill6_io", io1, 8'h00);
    @(negedge PCLK);
    check_val("ill6_err_once", bus.op_err, 0);
    check_val("ill6_ready", bus.op_ready, 1);

    do_op(3'd7, 8'h81, 1'b1, 0, lat, nwe_lo, nre_lo, pins1, io1, rdv_k);
    check_val("ill7_err", bus.op_err, 1);
    check_val("ill7_pins", pins1, 7'b1001110);
    repeat (2) @(negedge PCLK);
    check_val("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
